booth_mult: RTL

BOOTH_MULT -- requirements
Module: booth_mult

---
 rtl/booth_mult_if.sv | 20 ++
 rtl/booth_mult.sv | 121 ++++++++++++
 2 files changed

// File: rtl/booth_mult_if.sv
// Handshake and operand/result bundle between the control unit and the Booth multiplier.
interface booth_mult_if;
  logic        mult;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        fim;
  logic        busy;

  modport master (
    output mult, A, B,
    input  HI, LO, fim, busy
  );

  modport slave (
    input  mult, A, B,
    output HI, LO, fim, busy
  );
endinterface

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: 32x32 signed -> 64-bit product, one recoding step per clock.
module booth_mult (
  input  logic         clk,
  input  logic         reset,
  booth_mult_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [32:0] acc_reg,   acc_next;
  logic [31:0] q_reg,     q_next;
  logic [32:0] m_reg,     m_next;
  logic        q1_reg,    q1_next;
  logic [5:0]  cnt_reg,   cnt_next;
  logic [31:0] hi_reg,    hi_next;
  logic [31:0] lo_reg,    lo_next;
  logic        fim_reg,   fim_next;
  logic        busy_reg,  busy_next;

  logic [32:0] sum;
  logic [32:0] acc_shift;
  logic [31:0] q_shift;
  logic        q1_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      acc_reg   <= 33'd0;
      q_reg     <= 32'd0;
      m_reg     <= 33'd0;
      q1_reg    <= 1'b0;
      cnt_reg   <= 6'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      fim_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      m_reg     <= m_next;
      q1_reg    <= q1_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      fim_reg   <= fim_next;
      busy_reg  <= busy_next;
    end
  end

  // Booth step: 33-bit add/sub (carry discarded), then arithmetic shift of {acc,Q,q_1}.
  always_comb begin
    sum = acc_reg;
    case ({q_reg[0], q1_reg})
      2'b01:   sum = acc_reg + m_reg;
      2'b10:   sum = acc_reg - m_reg;
      default: sum = acc_reg;
    endcase
    acc_shift = {sum[32], sum[32:1]};
    q_shift   = {sum[0], q_reg[31:1]};
    q1_shift  = q_reg[0];
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    m_next     = m_reg;
    q1_next    = q1_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    fim_next   = 1'b0;
    busy_next  = busy_reg;

    case (state_reg)
      IDLE: begin
        if (bus.mult) begin
          m_next     = {bus.A[31], bus.A};
          q_next     = bus.B;
          acc_next   = 33'd0;
          q1_next    = 1'b0;
          cnt_next   = 6'd0;
          busy_next  = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        acc_next = acc_shift;
        q_next   = q_shift;
        q1_next  = q1_shift;
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == 6'd31) begin
          hi_next    = acc_shift[31:0];
          lo_next    = q_shift;
          state_next = DONE;
        end
      end
      DONE: begin
        // fim rises and busy falls together; mult is not looked at here.
        fim_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;
  assign bus.fim  = fim_reg;
  assign bus.busy = busy_reg;

endmodule
